// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and a small window-decode helper used by
// the timing core and by the downstream pixel renderers.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 32'd640;
  localparam int unsigned DEF_H_FRONT   = 32'd16;
  localparam int unsigned DEF_H_SYNC    = 32'd96;
  localparam int unsigned DEF_H_BACK    = 32'd48;
  localparam int unsigned DEF_V_VISIBLE = 32'd480;
  localparam int unsigned DEF_V_FRONT   = 32'd10;
  localparam int unsigned DEF_V_SYNC    = 32'd2;
  localparam int unsigned DEF_V_BACK    = 32'd33;
  localparam int unsigned DEF_POS_W     = 32'd10;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  // True when lo <= pos < hi (half-open window, unsigned).
  function automatic logic in_window(input int unsigned pos,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps MAX -> 0. o_wrap flags the enabled cycle whose
// edge performs the wrap, so it can chain the next counter stage.
module wrap_counter #(
  parameter int unsigned WIDTH     = 32'd10,
  parameter int unsigned MAX       = 32'd799,
  parameter int unsigned RESET_VAL = 32'd799
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};

  assign o_wrap = i_en & (o_count == MAX_C);

  // Count on enable, returning to zero after MAX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= RESET_C;
    end else if (i_en) begin
      if (o_wrap) begin
        o_count <= ZERO_C;
      end else begin
        o_count <= o_count + ONE_C;
      end
    end
  end

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing generator. Position counters plus sync/blank/strobe
// decode, all registered from the next-state position so every output
// describes the position shown on o_hpos/o_vpos in the same cycle.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned POS_W     = DEF_POS_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [POS_W-1:0] o_hpos,
  output logic [POS_W-1:0] o_vpos,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_hblank,
  output logic             o_vblank,
  output logic             o_visible,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic [15:0]      o_frame_count
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(32'd1);

  logic             h_wrap_s;
  logic             v_wrap_s;
  logic [POS_W-1:0] h_next_s;
  logic [POS_W-1:0] v_next_s;
  logic             hsync_next_s;
  logic             vsync_next_s;
  logic             hblank_next_s;
  logic             vblank_next_s;
  logic             line_start_next_s;
  logic             frame_start_next_s;

  // Reset parks both counters on the last pixel so the first edge lands on (0,0).
  wrap_counter #(
    .WIDTH     (POS_W),
    .MAX       (H_TOTAL - 32'd1),
    .RESET_VAL (H_TOTAL - 32'd1)
  ) u_hcount (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (1'b1),
    .o_count (o_hpos),
    .o_wrap  (h_wrap_s)
  );

  wrap_counter #(
    .WIDTH     (POS_W),
    .MAX       (V_TOTAL - 32'd1),
    .RESET_VAL (V_TOTAL - 32'd1)
  ) u_vcount (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (h_wrap_s),
    .o_count (o_vpos),
    .o_wrap  (v_wrap_s)
  );

  // Reconstruct the position the counters will hold after the coming edge.
  always_comb begin
    h_next_s = o_hpos;
    v_next_s = o_vpos;
    if (h_wrap_s) begin
      h_next_s = POS_ZERO;
    end else begin
      h_next_s = o_hpos + POS_ONE;
    end
    if (v_wrap_s) begin
      v_next_s = POS_ZERO;
    end else if (h_wrap_s) begin
      v_next_s = o_vpos + POS_ONE;
    end else begin
      v_next_s = o_vpos;
    end
  end

  // Decode sync, blanking and strobes for the next-state position.
  always_comb begin
    hsync_next_s       = ~HSYNC_POL;
    vsync_next_s       = ~VSYNC_POL;
    hblank_next_s      = (32'(h_next_s) >= H_VISIBLE);
    vblank_next_s      = (32'(v_next_s) >= V_VISIBLE);
    line_start_next_s  = (h_next_s == POS_ZERO);
    frame_start_next_s = (h_next_s == POS_ZERO) && (v_next_s == POS_ZERO);
    if (in_window(32'(h_next_s), HS_START, HS_END)) begin
      hsync_next_s = HSYNC_POL;
    end else begin
      hsync_next_s = ~HSYNC_POL;
    end
    if (in_window(32'(v_next_s), VS_START, VS_END)) begin
      vsync_next_s = VSYNC_POL;
    end else begin
      vsync_next_s = ~VSYNC_POL;
    end
  end

  // Register decoded outputs and the frame counter alongside the position counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync       <= ~HSYNC_POL;
      o_vsync       <= ~VSYNC_POL;
      o_hblank      <= 1'b1;
      o_vblank      <= 1'b1;
      o_visible     <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_count <= 16'hFFFF;
    end else begin
      o_hsync       <= hsync_next_s;
      o_vsync       <= vsync_next_s;
      o_hblank      <= hblank_next_s;
      o_vblank      <= vblank_next_s;
      o_visible     <= ~hblank_next_s & ~vblank_next_s;
      o_line_start  <= line_start_next_s;
      o_frame_start <= frame_start_next_s;
      if (frame_start_next_s) begin
        o_frame_count <= o_frame_count + 16'd1;
      end else begin
        o_frame_count <= o_frame_count;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// Self-checking bench for vga_timing_core. Expected outputs come from a model
// indexed by the number of clock edges since reset release; they are queued
// before each edge and popped after it. Three instances: default 640x480,
// a 14x7 active-high raster, and a 10x7 mixed-polarity raster.
module tb_vga_timing_core;

  typedef struct packed {
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        hsync;
    logic        vsync;
    logic        hblank;
    logic        vblank;
    logic        visible;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;
  } obs_t;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
    bit hp, vp;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_s;

  always #20 clk = ~clk;

  logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos, m_hpos, m_vpos;
  logic d_hsync, d_vsync, d_hblank, d_vblank, d_visible, d_line_start, d_frame_start;
  logic s_hsync, s_vsync, s_hblank, s_vblank, s_visible, s_line_start, s_frame_start;
  logic m_hsync, m_vsync, m_hblank, m_vblank, m_visible, m_line_start, m_frame_start;
  logic [15:0] d_frame_count, s_frame_count, m_frame_count;

  int checks = 0;
  int fails  = 0;
  int d_p, s_p, m_p;
  cfg_t d_cfg, s_cfg, m_cfg;
  obs_t d_q[$];
  obs_t s_q[$];
  obs_t m_q[$];

  vga_timing_core dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_hpos(d_hpos), .o_vpos(d_vpos),
    .o_hsync(d_hsync), .o_vsync(d_vsync), .o_hblank(d_hblank), .o_vblank(d_vblank),
    .o_visible(d_visible), .o_line_start(d_line_start), .o_frame_start(d_frame_start),
    .o_frame_count(d_frame_count)
  );

  vga_timing_core #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_s (
    .i_clk(clk), .i_rst_n(rst_n_s), .o_hpos(s_hpos), .o_vpos(s_vpos),
    .o_hsync(s_hsync), .o_vsync(s_vsync), .o_hblank(s_hblank), .o_vblank(s_vblank),
    .o_visible(s_visible), .o_line_start(s_line_start), .o_frame_start(s_frame_start),
    .o_frame_count(s_frame_count)
  );

  vga_timing_core #(
    .H_VISIBLE(6), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) dut_m (
    .i_clk(clk), .i_rst_n(rst_n_s), .o_hpos(m_hpos), .o_vpos(m_vpos),
    .o_hsync(m_hsync), .o_vsync(m_vsync), .o_hblank(m_hblank), .o_vblank(m_vblank),
    .o_visible(m_visible), .o_line_start(m_line_start), .o_frame_start(m_frame_start),
    .o_frame_count(m_frame_count)
  );

  // Expected outputs after p edges past reset release (p = -1 means in reset).
  function automatic obs_t model(input cfg_t c, input int p);
    obs_t m;
    int ht, vt, q, x, y, f;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    q  = p + ht * vt;
    x  = q % ht;
    y  = (q / ht) % vt;
    f  = q / (ht * vt) - 1;
    m.hpos        = 10'(x);
    m.vpos        = 10'(y);
    m.hsync       = (x >= c.hv + c.hf && x < c.hv + c.hf + c.hs) ? c.hp : ~c.hp;
    m.vsync       = (y >= c.vv + c.vf && y < c.vv + c.vf + c.vs) ? c.vp : ~c.vp;
    m.hblank      = (x >= c.hv);
    m.vblank      = (y >= c.vv);
    m.visible     = ~m.hblank & ~m.vblank;
    m.line_start  = (x == 0);
    m.frame_start = (x == 0) && (y == 0);
    m.frame_count = 16'(f);
    return m;
  endfunction

  function automatic obs_t obs_d();
    return {d_hpos, d_vpos, d_hsync, d_vsync, d_hblank, d_vblank, d_visible,
            d_line_start, d_frame_start, d_frame_count};
  endfunction

  function automatic obs_t obs_s();
    return {s_hpos, s_vpos, s_hsync, s_vsync, s_hblank, s_vblank, s_visible,
            s_line_start, s_frame_start, s_frame_count};
  endfunction

  function automatic obs_t obs_m();
    return {m_hpos, m_vpos, m_hsync, m_vsync, m_hblank, m_vblank, m_visible,
            m_line_start, m_frame_start, m_frame_count};
  endfunction

  task automatic test_reset();
    obs_t e, o;
    rst_n = 1'b0;
    rst_n_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d_q.push_back(model(d_cfg, -1));
      s_q.push_back(model(s_cfg, -1));
      @(posedge clk); #1;
      e = d_q.pop_front(); o = obs_d(); checks++;
      if (o !== e) begin fails++; $display("FAIL reset_hold_d cyc=%0d got=%h exp=%h", i, o, e); end
      e = s_q.pop_front(); o = obs_s(); checks++;
      if (o !== e) begin fails++; $display("FAIL reset_hold_s cyc=%0d got=%h exp=%h", i, o, e); end
    end
    checks++;
    if (d_hpos !== 10'd799 || d_vpos !== 10'd524) begin
      fails++; $display("FAIL reset_pos got=(%0d,%0d) exp=(799,524)", d_hpos, d_vpos);
    end
    checks++;
    if (d_hsync !== 1'b1 || d_vsync !== 1'b1 || d_visible !== 1'b0 || d_frame_count !== 16'hFFFF) begin
      fails++; $display("FAIL reset_outs got hs=%b vs=%b vis=%b fc=%h exp 1 1 0 ffff",
                        d_hsync, d_vsync, d_visible, d_frame_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d_p = -1;
  endtask

  task automatic test_first_edge();
    obs_t e, o;
    d_q.push_back(model(d_cfg, d_p + 1));
    @(posedge clk); #1;
    d_p++;
    e = d_q.pop_front(); o = obs_d(); checks++;
    if (o !== e) begin fails++; $display("FAIL first_edge got=%h exp=%h", o, e); end
    checks++;
    if (d_hpos !== 10'd0 || d_vpos !== 10'd0 || d_frame_start !== 1'b1 || d_line_start !== 1'b1 ||
        d_visible !== 1'b1 || d_frame_count !== 16'h0000) begin
      fails++; $display("FAIL first_edge_lit got pos=(%0d,%0d) fs=%b ls=%b vis=%b fc=%h exp (0,0) 1 1 1 0000",
                        d_hpos, d_vpos, d_frame_start, d_line_start, d_visible, d_frame_count);
    end
  endtask

  task automatic test_line();
    obs_t e, o;
    int vis = 0, hs_low = 0, ls = 0, last_ls = -1;
    for (int i = 0; i < 1600; i++) begin
      d_q.push_back(model(d_cfg, d_p + 1));
      @(posedge clk); #1;
      d_p++;
      e = d_q.pop_front(); o = obs_d(); checks++;
      if (o !== e) begin fails++; $display("FAIL line_sb p=%0d got=%h exp=%h", d_p, o, e); end
      if (d_visible) vis++;
      if (!d_hsync) hs_low++;
      if (d_line_start) begin
        ls++;
        if (last_ls >= 0) begin
          checks++;
          if (d_p - last_ls != 800) begin
            fails++; $display("FAIL line_period got=%0d exp=800", d_p - last_ls);
          end
        end
        last_ls = d_p;
      end
    end
    checks++;
    if (vis != 1280) begin fails++; $display("FAIL line_visible got=%0d exp=1280", vis); end
    checks++;
    if (hs_low != 192) begin fails++; $display("FAIL line_hsync_low got=%0d exp=192", hs_low); end
    checks++;
    if (ls != 2) begin fails++; $display("FAIL line_start_count got=%0d exp=2", ls); end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    bit found = 1'b0;
    for (int i = 0; i < 900 && !found; i++) begin
      d_q.push_back(model(d_cfg, d_p + 1));
      @(posedge clk); #1;
      d_p++;
      e = d_q.pop_front(); o = obs_d(); checks++;
      if (o !== e) begin fails++; $display("FAIL async_run p=%0d got=%h exp=%h", d_p, o, e); end
      if (d_hpos == 10'd300) found = 1'b1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL async_reach got=hpos %0d exp=300", d_hpos); end
    #5;
    d_q.push_back(model(d_cfg, -1));
    rst_n = 1'b0;
    #1;
    e = d_q.pop_front(); o = obs_d(); checks++;
    if (o !== e) begin fails++; $display("FAIL async_immediate got=%h exp=%h", o, e); end
    for (int i = 0; i < 3; i++) begin
      d_q.push_back(model(d_cfg, -1));
      @(posedge clk); #1;
      e = d_q.pop_front(); o = obs_d(); checks++;
      if (o !== e) begin fails++; $display("FAIL async_hold cyc=%0d got=%h exp=%h", i, o, e); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    d_p = -1;
    for (int i = 0; i < 20; i++) begin
      d_q.push_back(model(d_cfg, d_p + 1));
      @(posedge clk); #1;
      d_p++;
      e = d_q.pop_front(); o = obs_d(); checks++;
      if (o !== e) begin fails++; $display("FAIL async_restart p=%0d got=%h exp=%h", d_p, o, e); end
      if (i == 0) begin
        checks++;
        if (d_hpos !== 10'd0 || d_vpos !== 10'd0 || d_frame_count !== 16'h0000) begin
          fails++; $display("FAIL async_restart_lit got pos=(%0d,%0d) fc=%h exp (0,0) 0000",
                            d_hpos, d_vpos, d_frame_count);
        end
      end
    end
  endtask

  task automatic test_small_params();
    obs_t e, o;
    int hs_hi = 0, vs_hi = 0, bad_hs = 0, bad_vs = 0, fs = 0, fs_m = 0, wraps = 0, last_fs = -1;
    logic [9:0] max_v = 10'd0;
    logic [9:0] prev_h, prev_v;
    @(negedge clk);
    rst_n_s = 1'b1;
    s_p = -1;
    m_p = -1;
    for (int i = 0; i < 295; i++) begin
      s_q.push_back(model(s_cfg, s_p + 1));
      m_q.push_back(model(m_cfg, m_p + 1));
      prev_h = s_hpos;
      prev_v = s_vpos;
      @(posedge clk); #1;
      s_p++;
      m_p++;
      e = s_q.pop_front(); o = obs_s(); checks++;
      if (o !== e) begin fails++; $display("FAIL small_sb p=%0d got=%h exp=%h", s_p, o, e); end
      e = m_q.pop_front(); o = obs_m(); checks++;
      if (o !== e) begin fails++; $display("FAIL mixed_sb p=%0d got=%h exp=%h", m_p, o, e); end
      if (s_hsync) begin hs_hi++; if (s_hpos < 10'd10 || s_hpos > 10'd11) bad_hs++; end
      if (s_vsync) begin vs_hi++; if (s_vpos != 10'd5) bad_vs++; end
      if (s_vpos > max_v) max_v = s_vpos;
      if (m_frame_start) fs_m++;
      if (s_frame_start) begin
        fs++;
        checks++;
        if (s_frame_count !== 16'(s_p / 98)) begin
          fails++; $display("FAIL small_frame_count got=%h exp=%h", s_frame_count, 16'(s_p / 98));
        end
        if (last_fs >= 0) begin
          checks++;
          if (s_p - last_fs != 98) begin
            fails++; $display("FAIL small_frame_period got=%0d exp=98", s_p - last_fs);
          end
        end
        last_fs = s_p;
      end
      if (prev_h == 10'd13 && prev_v == 10'd6) begin
        wraps++;
        checks++;
        if (s_hpos !== 10'd0 || s_vpos !== 10'd0 || s_line_start !== 1'b1 || s_frame_start !== 1'b1) begin
          fails++; $display("FAIL double_wrap got pos=(%0d,%0d) ls=%b fs=%b exp (0,0) 1 1",
                            s_hpos, s_vpos, s_line_start, s_frame_start);
        end
      end
    end
    checks++;
    if (hs_hi != 42 || bad_hs != 0) begin
      fails++; $display("FAIL small_hsync got=%0d cycles %0d outside exp=42 0", hs_hi, bad_hs);
    end
    checks++;
    if (vs_hi != 42 || bad_vs != 0) begin
      fails++; $display("FAIL small_vsync got=%0d cycles %0d outside exp=42 0", vs_hi, bad_vs);
    end
    checks++;
    if (fs != 4 || wraps != 4) begin
      fails++; $display("FAIL small_frames got fs=%0d wraps=%0d exp 4 4", fs, wraps);
    end
    checks++;
    if (max_v > 10'd6) begin fails++; $display("FAIL small_vpos_max got=%0d exp<=6", max_v); end
    checks++;
    if (fs_m != 5) begin fails++; $display("FAIL mixed_frames got=%0d exp=5", fs_m); end
  endtask

  initial begin
    d_cfg = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    s_cfg = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1};
    m_cfg = '{6, 1, 2, 1, 3, 1, 2, 1, 1'b0, 1'b1};
    rst_n   = 1'b0;
    rst_n_s = 1'b0;
    test_reset();
    test_first_edge();
    test_line();
    test_async_reset();
    test_small_params();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule
